// File: rtl/wb_retire_queue_pkg.sv
// Shared writeback-queue types: the buffered entry layout and exception codes
// that the CSR unit decodes.
package wb_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_RADDR_W = 5;
  localparam int WB_EXC_W   = 6;

  localparam logic [WB_EXC_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [WB_EXC_W-1:0] ECODE_PIF  = 6'h03;
  localparam logic [WB_EXC_W-1:0] ECODE_ADE  = 6'h08;
  localparam logic [WB_EXC_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [WB_EXC_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [WB_EXC_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [WB_EXC_W-1:0] ECODE_INE  = 6'h0D;
  localparam logic [WB_EXC_W-1:0] ECODE_TLBR = 6'h3F;

  typedef struct packed {
    logic [WB_DATA_W-1:0]  pc;
    logic                  gr_we;
    logic [WB_RADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0]  result;
    logic                  ex;
    logic [WB_EXC_W-1:0]   ecode;
    logic                  ertn;
    logic                  refetch;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// One forwarding read port: walks the queue from head (oldest) to tail so the
// youngest matching entry overrides older ones.
module wb_fwd_lookup #(
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]        head_ptr,
  input  logic [DEPTH-1:0]        cand,
  input  logic [DEPTH*RADDR_W-1:0] dest,
  input  logic [DEPTH*DATA_W-1:0] result,
  input  logic [RADDR_W-1:0]      addr,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  logic [PTR_W-1:0] idx_s;
  logic             match_s;

  // age-ordered search, later (younger) matches replace earlier ones
  always_comb begin
    hit     = 1'b0;
    data    = '0;
    idx_s   = head_ptr;
    match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s   = head_ptr + PTR_W'(i);
      match_s = cand[idx_s] && (dest[idx_s*RADDR_W +: RADDR_W] == addr) && (addr != '0);
      hit     = hit | match_s;
      data    = match_s ? result[idx_s*DATA_W +: DATA_W] : data;
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback retire queue: buffers completed instructions, retires one
// per cycle, flushes on exception/ertn/refetch and forwards results to decode.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int DEPTH      = 2,
  parameter int EXC_W      = 6,
  parameter int NUM_LOOKUP = 2,
  parameter int CNT_W      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ms_to_ws_valid,
  output logic                          ws_allowin,
  input  logic [DATA_W-1:0]             ms_pc,
  input  logic                          ms_gr_we,
  input  logic [RADDR_W-1:0]            ms_dest,
  input  logic [DATA_W-1:0]             ms_result,
  input  logic                          ms_ex,
  input  logic [EXC_W-1:0]              ms_ecode,
  input  logic                          ms_ertn,
  input  logic                          ms_refetch,
  input  logic                          retire_stall,
  input  logic [NUM_LOOKUP*RADDR_W-1:0] lookup_addr,
  output logic [NUM_LOOKUP-1:0]         lookup_hit,
  output logic [NUM_LOOKUP*DATA_W-1:0]  lookup_data,
  output logic                          rf_we,
  output logic [RADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          wb_ex,
  output logic [EXC_W-1:0]              wb_ecode,
  output logic                          wb_ertn,
  output logic                          wb_refetch,
  output logic [DATA_W-1:0]             wb_pc,
  output logic [CNT_W-1:0]              retire_count,
  output logic [31:0]                   debug_wb_pc,
  output logic [3:0]                    debug_wb_rf_we,
  output logic [4:0]                    debug_wb_rf_wnum,
  output logic [31:0]                   debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  wb_entry_t              entry_r [DEPTH];
  logic [DEPTH-1:0]       valid_r;
  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic [OCC_W-1:0]       count_r;
  logic [CNT_W-1:0]       retire_count_r;

  wb_entry_t              head_s;
  wb_entry_t              new_s;
  logic                   retire_s;
  logic                   flush_s;
  logic                   enq_s;
  logic                   deq_s;
  logic [DEPTH-1:0]       cand_s;
  logic [DEPTH*RADDR_W-1:0] dest_flat_s;
  logic [DEPTH*DATA_W-1:0]  result_flat_s;

  assign head_s       = entry_r[head_r];
  assign ws_allowin   = (count_r != FULL_CNT);
  assign retire_s     = valid_r[head_r] && !retire_stall;
  assign flush_s      = retire_s && (head_s.ex || head_s.ertn || head_s.refetch);
  // a flushing retire discards whatever MEM offers in the same cycle
  assign enq_s        = ms_to_ws_valid && ws_allowin && !flush_s;
  assign deq_s        = retire_s && !flush_s;
  assign retire_count = retire_count_r;

  // pack the offered MEM-stage instruction into an entry
  always_comb begin
    new_s         = '0;
    new_s.pc      = WB_DATA_W'(ms_pc);
    new_s.gr_we   = ms_gr_we;
    new_s.dest    = WB_RADDR_W'(ms_dest);
    new_s.result  = WB_DATA_W'(ms_result);
    new_s.ex      = ms_ex;
    new_s.ecode   = WB_EXC_W'(ms_ecode);
    new_s.ertn    = ms_ertn;
    new_s.refetch = ms_refetch;
  end

  // payload storage; validity is tracked separately so no reset is needed here
  always_ff @(posedge clk) begin
    if (enq_s) begin
      entry_r[tail_r] <= new_s;
    end
  end

  // queue control: pointers, occupancy, valid bits and commit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r        <= '0;
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      retire_count_r <= '0;
    end else if (flush_s) begin
      valid_r <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      if (head_s.ertn && !head_s.ex) begin
        retire_count_r <= retire_count_r + CNT_W'(1);
      end
    end else begin
      if (enq_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1);
        retire_count_r  <= retire_count_r + CNT_W'(1);
      end
      count_r <= count_r + OCC_W'(enq_s) - OCC_W'(deq_s);
    end
  end

  // retire outputs decoded from the head, flush kinds in ex > ertn > refetch order
  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    wb_ex      = 1'b0;
    wb_ecode   = '0;
    wb_ertn    = 1'b0;
    wb_refetch = 1'b0;
    wb_pc      = '0;
    if (retire_s) begin
      wb_pc = DATA_W'(head_s.pc);
      if (head_s.ex) begin
        wb_ex    = 1'b1;
        wb_ecode = EXC_W'(head_s.ecode);
      end else if (head_s.ertn) begin
        wb_ertn = 1'b1;
      end else if (head_s.refetch) begin
        wb_refetch = 1'b1;
      end else begin
        rf_we    = head_s.gr_we && (head_s.dest != '0);
        rf_waddr = RADDR_W'(head_s.dest);
        rf_wdata = DATA_W'(head_s.result);
      end
    end else begin
      wb_pc = '0;
    end
  end

  assign debug_wb_pc       = 32'(wb_pc);
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = 5'(rf_waddr);
  assign debug_wb_rf_wdata = 32'(rf_wdata);

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign cand_s[i] = valid_r[i] && entry_r[i].gr_we && !entry_r[i].ex && !entry_r[i].refetch;
    assign dest_flat_s[i*RADDR_W +: RADDR_W] = RADDR_W'(entry_r[i].dest);
    assign result_flat_s[i*DATA_W +: DATA_W] = DATA_W'(entry_r[i].result);
  end

  for (genvar p = 0; p < NUM_LOOKUP; p++) begin : g_lookup
    wb_fwd_lookup #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .RADDR_W (RADDR_W),
      .PTR_W   (PTR_W)
    ) u_lookup (
      .head_ptr (head_r),
      .cand     (cand_s),
      .dest     (dest_flat_s),
      .result   (result_flat_s),
      .addr     (lookup_addr[p*RADDR_W +: RADDR_W]),
      .hit      (lookup_hit[p]),
      .data     (lookup_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: a queue-based model predicts retires and
// per-cycle status; a negedge monitor pops and compares.
module tb_wb_retire_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic        ms_ertn;
  logic        ms_refetch;
  logic        retire_stall;
  logic [9:0]  lookup_addr;
  logic [1:0]  lookup_hit;
  logic [63:0] lookup_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic        wb_ertn;
  logic        wb_refetch;
  logic [31:0] wb_pc;
  logic [63:0] retire_count;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_retire_queue dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_ertn(ms_ertn), .ms_refetch(ms_refetch),
    .retire_stall(retire_stall), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_ertn(wb_ertn), .wb_refetch(wb_refetch),
    .wb_pc(wb_pc), .retire_count(retire_count), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic [31:0] pc; bit gr_we; logic [4:0] dest; logic [31:0] result;
    bit ex; logic [5:0] ecode; bit ertn; bit refetch;
  } ent_t;
  typedef struct {
    logic [31:0] pc; bit rf_we; logic [4:0] waddr; logic [31:0] wdata;
    bit ex; logic [5:0] ecode; bit ertn; bit refetch;
  } ret_t;
  typedef struct {
    bit allowin; logic [63:0] rc; logic [1:0] hit; logic [63:0] data;
  } stat_t;

  ent_t        mq[$];
  ret_t        ret_q[$];
  stat_t       stat_q[$];
  logic [63:0] m_rc;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          pc_seq = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] next_pc();
    pc_seq++;
    return 32'h1C000100 + 32'(pc_seq) * 32'd4;
  endfunction

  // youngest valid forwarding-eligible entry matching a register
  function automatic void model_lookup(input logic [4:0] a, output bit h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!h && mq[i].gr_we && mq[i].dest == a && !mq[i].ex && !mq[i].refetch) begin
          h = 1'b1;
          d = mq[i].result;
        end
      end
    end
  endfunction

  // one clock cycle of stimulus: called at posedge+1, returns at next posedge+1
  task automatic cycle(input bit v, input bit st, input logic [31:0] pc, input bit gwe,
                       input logic [4:0] dst, input logic [31:0] res, input bit ex,
                       input logic [5:0] ec, input bit er, input bit rf,
                       input logic [4:0] la0, input logic [4:0] la1);
    bit allow, ret, flushing, h0, h1;
    logic [31:0] d0, d1;
    ent_t hd, ne;
    ret_t r;
    stat_t s;
    ms_to_ws_valid = v; retire_stall = st; ms_pc = pc; ms_gr_we = gwe; ms_dest = dst;
    ms_result = res; ms_ex = ex; ms_ecode = ec; ms_ertn = er; ms_refetch = rf;
    lookup_addr = {la1, la0};
    allow = (mq.size() != DEPTH);
    ret   = (mq.size() > 0) && !st;
    model_lookup(la0, h0, d0);
    model_lookup(la1, h1, d1);
    s.allowin = allow; s.rc = m_rc; s.hit = {h1, h0}; s.data = {d1, d0};
    stat_q.push_back(s);
    flushing = 1'b0;
    r = '{default: 0};
    if (ret) begin
      hd = mq[0];
      flushing  = hd.ex || hd.ertn || hd.refetch;
      r.pc      = hd.pc;
      r.ex      = hd.ex;
      r.ecode   = hd.ex ? hd.ecode : 6'd0;
      r.ertn    = !hd.ex && hd.ertn;
      r.refetch = !hd.ex && !hd.ertn && hd.refetch;
      r.rf_we   = !flushing && hd.gr_we && hd.dest != 5'd0;
      r.waddr   = r.rf_we ? hd.dest : 5'd0;
      r.wdata   = r.rf_we ? hd.result : 32'd0;
      ret_q.push_back(r);
    end
    @(posedge clk);
    if (ret && flushing) begin
      mq.delete();
      if (r.ertn) m_rc++;
    end else begin
      if (ret) begin
        void'(mq.pop_front());
        m_rc++;
      end
      if (v && allow) begin
        ne = '{pc: pc, gr_we: gwe, dest: dst, result: res, ex: ex, ecode: ec, ertn: er, refetch: rf};
        mq.push_back(ne);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit st, input logic [4:0] la0, input logic [4:0] la1);
    for (int i = 0; i < n; i++) cycle(1'b0, st, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0, la0, la1);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, next_pc(),
            $urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 8, 6'($urandom_range(0, 63)),
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
  endtask

  ret_t  r_m;
  stat_t s_m;
  logic  seen_m;

  // monitor: compare per-cycle status and any presented retire against the scoreboard
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (stat_q.size() > 0) begin
        s_m = stat_q.pop_front();
        chk("status", {ws_allowin, retire_count, lookup_hit, lookup_data},
                      {s_m.allowin, s_m.rc, s_m.hit, s_m.data});
      end
      seen_m = (wb_pc != 32'd0) || rf_we || wb_ex || wb_ertn || wb_refetch;
      if (seen_m) begin
        if (ret_q.size() == 0) begin
          chk("unexpected_retire", {wb_pc, rf_we, wb_ex, wb_ertn, wb_refetch}, 256'd0);
        end else begin
          r_m = ret_q.pop_front();
          chk("retire",
              {wb_pc, rf_we, rf_we ? rf_waddr : 5'd0, rf_we ? rf_wdata : 32'd0, wb_ex, wb_ecode,
               wb_ertn, wb_refetch, debug_wb_pc, debug_wb_rf_we,
               rf_we ? debug_wb_rf_wnum : 5'd0, rf_we ? debug_wb_rf_wdata : 32'd0},
              {r_m.pc, r_m.rf_we, r_m.waddr, r_m.wdata, r_m.ex, r_m.ecode,
               r_m.ertn, r_m.refetch, r_m.pc, {4{r_m.rf_we}}, r_m.waddr, r_m.wdata});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_pc = 32'd0; ms_gr_we = 1'b0; ms_dest = 5'd0;
    ms_result = 32'd0; ms_ex = 1'b0; ms_ecode = 6'd0; ms_ertn = 1'b0; ms_refetch = 1'b0;
    retire_stall = 1'b0; lookup_addr = {5'd2, 5'd1};
    m_rc = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_allowin", 256'(ws_allowin), 256'd1);
    chk("reset_outputs", {wb_pc, rf_we, wb_ex, wb_ertn, wb_refetch, lookup_hit, lookup_data}, 256'd0);
    chk("reset_count", 256'(retire_count), 256'd0);
    mon_en = 1'b1;

    // back-to-back enqueue with no stall
    cycle(1, 0, next_pc(), 1, 5'd1, 32'h11, 0, 6'd0, 0, 0, 5'd1, 5'd0);
    cycle(1, 0, next_pc(), 1, 5'd2, 32'h22, 0, 6'd0, 0, 0, 5'd2, 5'd1);
    cycle(1, 0, next_pc(), 1, 5'd3, 32'h33, 0, 6'd0, 0, 0, 5'd3, 5'd2);
    idle(3, 0, 5'd3, 5'd0);
    chk("count_after_three", 256'(retire_count), 256'd3);

    // stall fills the queue, release drains in order
    cycle(1, 1, next_pc(), 1, 5'd4, 32'h44, 0, 6'd0, 0, 0, 5'd4, 5'd0);
    cycle(1, 1, next_pc(), 1, 5'd5, 32'h55, 0, 6'd0, 0, 0, 5'd4, 5'd5);
    cycle(1, 1, next_pc(), 1, 5'd6, 32'h66, 0, 6'd0, 0, 0, 5'd6, 5'd5);
    idle(3, 0, 5'd4, 5'd5);

    // exception at head of a full queue, with an offered entry
    cycle(1, 1, 32'h1C000010, 1, 5'd6, 32'h77, 1, 6'h0B, 0, 0, 5'd6, 5'd0);
    cycle(1, 1, next_pc(), 1, 5'd7, 32'h88, 0, 6'd0, 0, 0, 5'd7, 5'd6);
    cycle(1, 0, next_pc(), 1, 5'd8, 32'h99, 0, 6'd0, 0, 0, 5'd8, 5'd7);
    idle(2, 0, 5'd8, 5'd7);
    // exception with room: same-cycle enqueue is dropped
    cycle(1, 1, next_pc(), 1, 5'd9, 32'hAA, 1, 6'h0D, 0, 0, 5'd9, 5'd0);
    cycle(1, 0, next_pc(), 1, 5'd10, 32'hBB, 0, 6'd0, 0, 0, 5'd10, 5'd9);
    idle(2, 0, 5'd10, 5'd9);

    // youngest-match forwarding
    cycle(1, 1, next_pc(), 1, 5'd5, 32'hA, 0, 6'd0, 0, 0, 5'd5, 5'd0);
    cycle(1, 1, next_pc(), 1, 5'd5, 32'hB, 0, 6'd0, 0, 0, 5'd5, 5'd0);
    idle(1, 1, 5'd5, 5'd0);
    idle(3, 0, 5'd5, 5'd0);

    // ex+ertn retires as ex only; ertn alone counts
    cycle(1, 0, next_pc(), 0, 5'd0, 32'd0, 1, 6'h0C, 1, 0, 5'd0, 5'd0);
    idle(1, 0, 5'd0, 5'd0);
    cycle(1, 0, next_pc(), 0, 5'd0, 32'd0, 0, 6'd0, 1, 0, 5'd0, 5'd0);
    idle(1, 0, 5'd0, 5'd0);
    cycle(1, 0, next_pc(), 1, 5'd3, 32'hCC, 0, 6'd0, 0, 1, 5'd3, 5'd0);
    idle(2, 0, 5'd3, 5'd0);

    rand_cycles(300);

    // asynchronous reset while full with the head retiring
    idle(4, 0, 5'd0, 5'd0);
    cycle(1, 1, 32'h1C00F000, 1, 5'd2, 32'h1234, 0, 6'd0, 0, 0, 5'd2, 5'd0);
    cycle(1, 1, next_pc(), 1, 5'd3, 32'h5678, 0, 6'd0, 0, 0, 5'd2, 5'd3);
    ms_to_ws_valid = 1'b0; retire_stall = 1'b0;
    #1;
    chk("pre_reset_head", {wb_pc, rf_we, ws_allowin}, {32'h1C00F000, 1'b1, 1'b0});
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {wb_pc, rf_we, rf_waddr, rf_wdata, wb_ex, wb_ertn, wb_refetch,
                                lookup_hit, lookup_data, debug_wb_rf_we}, 256'd0);
    chk("async_reset_count", 256'(retire_count), 256'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    mq.delete();
    m_rc = 64'd0;
    @(posedge clk); #1;
    chk("post_reset_allowin", 256'(ws_allowin), 256'd1);

    rand_cycles(150);
    for (int i = 0; i < 20 && mq.size() > 0; i++) idle(1, 0, 5'd1, 5'd2);
    idle(2, 0, 5'd1, 5'd2);
    chk("drained_model", 256'(mq.size()), 256'd0);
    chk("retire_q_empty", 256'(ret_q.size()), 256'd0);
    chk("stat_q_empty", 256'(stat_q.size()), 256'd0);
    chk("final_count", 256'(retire_count), 256'(m_rc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
Name: wb_retire_queue

Overview:
- Parametrised successor to the single-register writeback stage. Sits between the MEM stage and the register file / CSR unit.
- Buffers up to DEPTH completed instructions and retires one per cycle in program order. Retirement can be held by an external stall, for example while the CSR or TLB unit is busy.
- Signals exceptions, ertn and refetch at retire and flushes the whole queue when one occurs.
- Provides youngest-match result forwarding to the decode stage over NUM_LOOKUP read ports.

Parameters:
- DATA_W, 32, data/PC width
- RADDR_W, 5, register address width
- DEPTH, 2, queue entries; power of 2, ≥2
- EXC_W, 6, exception code width
- NUM_LOOKUP, 2, number of forwarding lookup ports
- CNT_W, 64, retired-instruction counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- ms_to_ws_valid  in  1  MEM stage offers an entry
- ws_allowin  out  1  queue can accept an entry
- ms_pc  in  DATA_W  PC of the offered entry
- ms_gr_we  in  1  entry writes the register file
- ms_dest  in  RADDR_W  destination register
- ms_result  in  DATA_W  result to write
- ms_ex  in  1  entry carries an exception
- ms_ecode  in  EXC_W  exception code
- ms_ertn  in  1  entry is ertn
- ms_refetch  in  1  entry requires refetch
- retire_stall  in  1  hold the head entry
- lookup_addr  in  NUM_LOOKUP*RADDR_W  register numbers to search
- lookup_hit  out  NUM_LOOKUP  per-port match found
- lookup_data  out  NUM_LOOKUP*DATA_W  per-port forwarded data
- rf_we  out  1  register file write enable
- rf_waddr  out  RADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- wb_ex  out  1  exception retired this cycle
- wb_ecode  out  EXC_W  code of the retired exception
- wb_ertn  out  1  ertn retired this cycle
- wb_refetch  out  1  refetch retired this cycle
- wb_pc  out  DATA_W  PC of the retiring entry
- retire_count  out  CNT_W  count of committed instructions
- debug_wb_pc  out  32  trace: PC
- debug_wb_rf_we  out  4  trace: write enable
- debug_wb_rf_wnum  out  5  trace: write register
- debug_wb_rf_wdata  out  32  trace: write data

Behaviour:
- Reset (async, active-high):
  - all entries invalid; head/tail pointers 0; count 0; retire_count 0.
  - All retire outputs and lookup outputs 0. ws_allowin is 1 on the first cycle after reset.
- Structure and enqueue:
  - Circular FIFO with a (log2(DEPTH)+1)-bit occupancy count.
  - ws_allowin = (count != DEPTH); it never depends on ms_to_ws_valid.
  - Enqueue happens at the edge where ms_to_ws_valid && ws_allowin.
  - When full, no enqueue occurs, even in a cycle where the head retires; there is no full-queue bypass.
- Head and retire:
  - The head is visible combinationally from the cycle after its enqueue, so latency is 1.
  - The head retires when it is valid && !retire_stall. All wb_*, rf_* and debug_* outputs are combinational from the head register and are gated by that retire condition.
- Normal retire:
  - rf_we = gr_we && (dest != 0); dequeue; retire_count += 1, wrapping at 2^CNT_W.
- Flush retire:
  - Priority is ex > ertn > refetch, and exactly one of wb_ex, wb_ertn or wb_refetch asserts.
  - rf_we = 0, wb_pc = head PC, and wb_ecode is valid only with wb_ex.
  - At the next edge all entries are invalidated, count goes to 0, and any same-cycle enqueue is dropped.
  - retire_count increments for ertn only; it does not increment for ex or refetch.
- Simultaneous enqueue and normal retire: the count is unchanged and the pointers both advance.
- retire_stall held: the head and all outputs are stable. retire_count does not change.
- Empty queue: all retire outputs are 0 and ws_allowin is 1.
- Lookup (combinational):
  - For each port, search the valid entries with gr_we, dest == addr, addr != 0 and no ex/refetch flag.
  - The youngest match wins. When there is no match, lookup_hit = 0 and lookup_data = 0.
  - The head entry is included in the search even in its retiring cycle.
- Trace outputs: debug_wb_rf_we = {4{rf_we}}. debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata mirror wb_pc, rf_waddr and rf_wdata; narrower fields are zero-extended.
- Pointers wrap modulo DEPTH.

Decomposition:
- Package wb_pkg holds:
  - the typedef wb_entry_t {pc, gr_we, dest, result, ex, ecode, ertn, refetch};
  - the ECODE_* constants shared with the CSR unit.
- Sub-module wb_fwd_lookup: one instance per lookup port. It performs an age-ordered youngest-match search over the DEPTH entries, using the head pointer.

Test Plan:
- Back-to-back enqueue of 3 entries (dest 1/2/3, data 0x11/0x22/0x33) with no stall, DEPTH=2: rf writes occur in order on consecutive cycles, ws_allowin never deasserts, and retire_count = 3.
- retire_stall=1 with 2 enqueues: ws_allowin=0 after the second. Release the stall: retires follow in order and ws_allowin returns to 1.
- Head has ms_ex=1 with ecode 0x0B at pc 0x1C000010, queue holding 2 entries, plus an enqueue in the same cycle: wb_ex=1, wb_ecode=0x0B, wb_pc=0x1C000010, rf_we=0; the queue is empty next cycle and retire_count is unchanged.
- Entries with dest 5 (0xA) and then dest 5 (0xB) queued; lookup_addr=5 gives hit=1 and data 0xB. lookup_addr=0 gives hit=0.
- Entry with ex and ertn both set: only wb_ex asserts. Entry with ertn alone: wb_ertn=1 and retire_count +1.
- Assert reset mid-operation while the queue is full: the outputs clear asynchronously and ws_allowin=1 after release.
